// File: rtl/cbfp_block_norm_pkg.sv
// Shared types, sizing and arithmetic helpers for the block-floating-point normaliser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cbfp_pkg;

    localparam int LANES     = 16;
    localparam int BEATS     = 4;
    localparam int DIN_W     = 23;
    localparam int DOUT_W    = 11;
    localparam int MAX_SHIFT = 12;
    localparam int EXP_W     = 5;

    localparam int LRS_W = $clog2(DIN_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SHR   = DIN_W - DOUT_W;
    localparam int SUM_W = DIN_W + 1;

    localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(1 << (SHR - 1));
    localparam logic signed [SUM_W-1:0] OUT_MAX  = SUM_W'((1 << (DOUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN  = SUM_W'(-(1 << (DOUT_W - 1)));

    typedef logic signed [DIN_W-1:0]  sample_t;
    typedef logic signed [DOUT_W-1:0] osample_t;

    // Per-bank bookkeeping: full flag, latched block shift, running min of lrs.
    typedef struct packed {
        logic             full;
        logic [EXP_W-1:0] shift;
        logic [LRS_W-1:0] min_lrs;
    } bank_t;

    typedef enum logic {
        DRN_IDLE   = 1'b0,
        DRN_STREAM = 1'b1
    } drn_state_e;

    // Leading redundant sign bits: run of bits below the MSB that equal the MSB.
    function automatic logic [LRS_W-1:0] lrs_f(input sample_t x);
        logic [LRS_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int i = DIN_W - 2; i >= 0; i--) begin
            if (run && (x[i] == x[DIN_W-1])) begin
                n = n + LRS_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // Round half up by adding half an output LSB, drop SHR bits, clamp to DOUT_W.
    function automatic osample_t sat_round_f(input sample_t y);
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] r;
        sum = {y[DIN_W-1], y} + RND_BIAS;
        r   = sum >>> SHR;
        if (r > OUT_MAX) begin
            r = OUT_MAX;
        end else if (r < OUT_MIN) begin
            r = OUT_MIN;
        end
        return r[DOUT_W-1:0];
    endfunction

endpackage

// File: rtl/cbfp_block_norm_lrs_min.sv
// Minimum leading-redundant-sign count across all lanes of one input beat.
// Latency: combinational.
// Backpressure: none; the caller qualifies the result with its accept strobe.
module cbfp_lrs_min
    import cbfp_pkg::*;
(
    input  sample_t          din [0:LANES-1],
    output logic [LRS_W-1:0] min_lrs
);

    // Linear min scan; LANES is small enough that a tree buys nothing here.
    always_comb begin
        min_lrs = lrs_f(din[0]);
        for (int i = 1; i < LANES; i++) begin
            if (lrs_f(din[i]) < min_lrs) begin
                min_lrs = lrs_f(din[i]);
            end
        end
    end

endmodule

// File: rtl/cbfp_block_norm.sv
// Ping-pong block normaliser: buffers a block, finds its common shift, replays it scaled.
// Latency: first output beat is valid the cycle after the block's last input beat is accepted.
// Backpressure: ready_in drops while both banks are full; outputs hold while valid_out && !ready_out.
module cbfp_block_norm
    import cbfp_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    output logic             ready_in,
    input  sample_t          din [0:LANES-1],
    output logic             valid_out,
    input  logic             ready_out,
    output osample_t         dout [0:LANES-1],
    output logic [EXP_W-1:0] exp_out,
    output logic             sob_out,
    output logic             eob_out
);

    sample_t          mem_q [2][BEATS][LANES];
    sample_t          mem_d [2][BEATS][LANES];
    bank_t            bank_q [2];
    bank_t            bank_f [2];
    bank_t            bank_d [2];
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    drn_state_e       state_q, state_d;
    logic             valid_out_q, valid_out_d, sob_q, sob_d, eob_q, eob_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    osample_t         dout_q [LANES];
    osample_t         dout_d [LANES];

    logic [LRS_W-1:0] beat_min, blk_min;
    logic             in_acc, last_in, out_adv, load, rd_last;

    cbfp_lrs_min u_lrs_min (
        .din     (din),
        .min_lrs (beat_min)
    );

    assign ready_in = !bank_q[wr_bank_q].full;
    assign in_acc   = valid_in && ready_in;
    assign last_in  = in_acc && (wr_cnt_q == CNT_W'(BEATS - 1));

    // Fill side: store the beat, fold its lrs into the bank minimum, close the block on the last beat.
    always_comb begin
        mem_d     = mem_q;
        bank_f    = bank_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        blk_min   = beat_min;
        if ((wr_cnt_q != '0) && (bank_q[wr_bank_q].min_lrs < beat_min)) begin
            blk_min = bank_q[wr_bank_q].min_lrs;
        end
        if (in_acc) begin
            mem_d[wr_bank_q][wr_cnt_q]  = din;
            bank_f[wr_bank_q].min_lrs   = blk_min;
            if (last_in) begin
                bank_f[wr_bank_q].full  = 1'b1;
                bank_f[wr_bank_q].shift = (blk_min > LRS_W'(MAX_SHIFT)) ? EXP_W'(MAX_SHIFT)
                                                                         : EXP_W'(blk_min);
                wr_bank_d               = ~wr_bank_q;
                wr_cnt_d                = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
    end

    // Drain side: reads the post-fill view so a block closing this cycle starts draining at once.
    always_comb begin
        bank_d      = bank_f;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        state_d     = state_q;
        valid_out_d = valid_out_q;
        exp_d       = exp_q;
        sob_d       = sob_q;
        eob_d       = eob_q;
        dout_d      = dout_q;
        out_adv     = !valid_out_q || ready_out;
        load        = out_adv && bank_f[rd_bank_q].full;
        rd_last     = (rd_cnt_q == CNT_W'(BEATS - 1));

        case (state_q)
            DRN_IDLE: begin
                if (load) begin
                    state_d = (rd_last && !bank_f[~rd_bank_q].full) ? DRN_IDLE : DRN_STREAM;
                end
            end
            DRN_STREAM: begin
                if (load && rd_last) begin
                    state_d = bank_f[~rd_bank_q].full ? DRN_STREAM : DRN_IDLE;
                end
            end
        endcase

        if (load) begin
            valid_out_d = 1'b1;
            exp_d       = bank_f[rd_bank_q].shift;
            sob_d       = (rd_cnt_q == '0);
            eob_d       = rd_last;
            for (int i = 0; i < LANES; i++) begin
                dout_d[i] = sat_round_f(mem_d[rd_bank_q][rd_cnt_q][i] <<< bank_f[rd_bank_q].shift);
            end
            if (rd_last) begin
                bank_d[rd_bank_q].full = 1'b0;
                rd_bank_d              = ~rd_bank_q;
                rd_cnt_d               = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
        end else if (out_adv) begin
            valid_out_d = 1'b0;
        end
    end

    // Control and output registers; reset discards every partial or full block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q      <= '{default: '0};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            state_q     <= DRN_IDLE;
            valid_out_q <= 1'b0;
            exp_q       <= '0;
            sob_q       <= 1'b0;
            eob_q       <= 1'b0;
            dout_q      <= '{default: '0};
        end else begin
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            state_q     <= state_d;
            valid_out_q <= valid_out_d;
            exp_q       <= exp_d;
            sob_q       <= sob_d;
            eob_q       <= eob_d;
            dout_q      <= dout_d;
        end
    end

    // Sample storage needs no reset: contents are only read behind a set full flag.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid_out = valid_out_q;
    assign dout      = dout_q;
    assign exp_out   = exp_q;
    assign sob_out   = sob_q;
    assign eob_out   = eob_q;

endmodule

// File: tb/tb_cbfp_block_norm.sv
module tb_cbfp_block_norm;
    import cbfp_pkg::*;

    typedef sample_t beat_in_t [LANES];
    typedef struct packed {
        logic [EXP_W-1:0]               e;
        logic                           sob;
        logic                           eob;
        logic [LANES-1:0][DOUT_W-1:0]   d;
    } beat_t;

    localparam longint LO = -(longint'(1) <<< (DIN_W - 1));
    localparam longint HI = (longint'(1) <<< (DIN_W - 1)) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             valid_in = 1'b0;
    logic             ready_out = 1'b0;
    logic             ready_in, valid_out, sob_out, eob_out;
    sample_t          din [LANES];
    osample_t         dout [LANES];
    logic [EXP_W-1:0] exp_out;

    beat_in_t nxt;
    beat_in_t mdl_blk[$];
    beat_t    exp_q[$];
    beat_t    obs_q[$];
    int       n_cmp = 0;
    int       n_err = 0;

    cbfp_block_norm dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .din       (din),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .dout      (dout),
        .exp_out   (exp_out),
        .sob_out   (sob_out),
        .eob_out   (eob_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Largest shift for which x * 2^s still fits the input format.
    function automatic int lrs_ref(input longint x);
        int s = 0;
        for (int k = 0; k < DIN_W; k++) begin
            if ((x * (longint'(1) <<< k) >= LO) && (x * (longint'(1) <<< k) <= HI)) s = k;
        end
        return s;
    endfunction

    function automatic int out_ref(input longint x, input int s);
        longint y, q, den;
        den = longint'(1) <<< (DIN_W - DOUT_W);
        y   = x * (longint'(1) <<< s) + den / 2;
        q   = y / den;
        if ((y < 0) && (q * den != y)) q = q - 1;
        if (q > (2 ** (DOUT_W - 1)) - 1) q = (2 ** (DOUT_W - 1)) - 1;
        if (q < -(2 ** (DOUT_W - 1))) q = -(2 ** (DOUT_W - 1));
        return int'(q);
    endfunction

    task automatic model_push(input beat_in_t b);
        int    m;
        int    s;
        beat_t t;
        mdl_blk.push_back(b);
        if (mdl_blk.size() == BEATS) begin
            m = DIN_W - 1;
            for (int k = 0; k < BEATS; k++)
                for (int i = 0; i < LANES; i++)
                    if (lrs_ref(longint'(mdl_blk[k][i])) < m) m = lrs_ref(longint'(mdl_blk[k][i]));
            s = (m > MAX_SHIFT) ? MAX_SHIFT : m;
            for (int k = 0; k < BEATS; k++) begin
                t.e   = EXP_W'(s);
                t.sob = (k == 0);
                t.eob = (k == BEATS - 1);
                for (int i = 0; i < LANES; i++) t.d[i] = DOUT_W'(out_ref(longint'(mdl_blk[k][i]), s));
                exp_q.push_back(t);
            end
            mdl_blk.delete();
        end
    endtask

    task automatic model_clear();
        mdl_blk.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- stimulus ----------------
    // One cycle: drive after negedge, then record the handshakes that the next posedge will complete.
    task automatic step(input bit vin, input bit rout, output bit acc, output bit got);
        beat_t t;
        @(negedge clk);
        valid_in  = vin;
        ready_out = rout;
        din       = nxt;
        #1;
        acc = valid_in && ready_in;
        got = valid_out && ready_out;
        if (acc) model_push(din);
        if (got) begin
            t.e   = exp_out;
            t.sob = sob_out;
            t.eob = eob_out;
            for (int i = 0; i < LANES; i++) t.d[i] = dout[i];
            obs_q.push_back(t);
        end
    endtask

    task automatic rand_nxt(input int mag);
        longint v;
        for (int i = 0; i < LANES; i++) begin
            v = longint'($urandom) & ((longint'(1) <<< mag) - 1);
            if ($urandom_range(0, 1) == 1) v = -v - 1;
            nxt[i] = sample_t'(v);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit dz;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        dz = 1'b1;
        for (int i = 0; i < LANES; i++) if (dout[i] !== '0) dz = 1'b0;
        n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL rst_ready_in got %b want 1", ready_in); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid_out got %b want 0", valid_out); end
        n_cmp++; if (exp_out !== '0) begin n_err++; $display("FAIL rst_exp got %0d want 0", exp_out); end
        n_cmp++; if ({sob_out, eob_out} !== 2'b00) begin n_err++; $display("FAIL rst_sob_eob got %b want 00", {sob_out, eob_out}); end
        n_cmp++; if (!dz) begin n_err++; $display("FAIL rst_dout got nonzero want 0"); end
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
    endtask

    task automatic test_single_block();
        bit acc, got;
        for (int i = 0; i < LANES; i++) nxt[i] = 23'sd256;
        for (int b = 0; b < BEATS; b++) step(1'b1, 1'b1, acc, got);
        step(1'b0, 1'b1, acc, got);
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL latency valid_out got %b want 1", valid_out); end
        repeat (8) step(1'b0, 1'b1, acc, got);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL single_beat%0d got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        if (obs_q.size() > 0) begin
            n_cmp++; if (obs_q[0].e !== 5'd12) begin n_err++; $display("FAIL single_exp got %0d want 12", obs_q[0].e); end
        end
        model_clear();
    endtask

    task automatic test_back_to_back();
        beat_in_t blks [3*BEATS];
        bit acc, got;
        int idx = 0, first = -1, last = -1, ngot = 0;
        for (int k = 0; k < 3 * BEATS; k++)
            for (int i = 0; i < LANES; i++) blks[k][i] = (k < 8) ? 23'sd0 : 23'sd4096;
        blks[2][5] = -23'sd4194304;
        blks[5][3] = 23'sd4194303;
        for (int c = 0; c < 60; c++) begin
            if (idx < 3 * BEATS) nxt = blks[idx];
            step(idx < 3 * BEATS, 1'b1, acc, got);
            if (acc) idx++;
            if (got) begin
                if (first < 0) first = c;
                last = c;
                ngot++;
            end
        end
        n_cmp++; if (idx != 12) begin n_err++; $display("FAIL b2b_accepted got %0d want 12", idx); end
        n_cmp++; if (ngot != 12) begin n_err++; $display("FAIL b2b_outputs got %0d want 12", ngot); end
        n_cmp++; if (first != 4) begin n_err++; $display("FAIL b2b_first_cycle got %0d want 4", first); end
        n_cmp++; if (last - first != 11) begin n_err++; $display("FAIL b2b_bubbles span got %0d want 11", last - first); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL b2b_beat%0d got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        if (obs_q.size() == 12) begin
            n_cmp++; if ({obs_q[2].e, obs_q[2].d[5]} !== {5'd0, 11'h400}) begin n_err++; $display("FAIL neg_full e=%0d d=%h want 0 400", obs_q[2].e, obs_q[2].d[5]); end
            n_cmp++; if ({obs_q[5].e, obs_q[5].d[3]} !== {5'd0, 11'h3ff}) begin n_err++; $display("FAIL pos_sat e=%0d d=%h want 0 3ff", obs_q[5].e, obs_q[5].d[3]); end
            n_cmp++; if ({obs_q[8].e, obs_q[8].d[0]} !== {5'd9, 11'h200}) begin n_err++; $display("FAIL blk4096 e=%0d d=%h want 9 200", obs_q[8].e, obs_q[8].d[0]); end
        end
        model_clear();
    endtask

    task automatic test_backpressure();
        beat_in_t blks [3*BEATS];
        bit acc, got;
        int idx = 0;
        beat_t hold_a, hold_b;
        for (int k = 0; k < 3 * BEATS; k++) begin
            rand_nxt(4 + 7 * (k / BEATS) + (k % 2));
            blks[k] = nxt;
        end
        for (int c = 0; c < 20; c++) begin
            if (idx < 3 * BEATS) nxt = blks[idx];
            step(idx < 3 * BEATS, 1'b0, acc, got);
            if (acc) idx++;
            if (c == 10) hold_a = {exp_out, sob_out, eob_out, dout[0], dout[1], dout[2], dout[3], dout[4], dout[5], dout[6], dout[7],
                                   dout[8], dout[9], dout[10], dout[11], dout[12], dout[13], dout[14], dout[15]};
            if (c == 19) hold_b = {exp_out, sob_out, eob_out, dout[0], dout[1], dout[2], dout[3], dout[4], dout[5], dout[6], dout[7],
                                   dout[8], dout[9], dout[10], dout[11], dout[12], dout[13], dout[14], dout[15]};
        end
        n_cmp++; if (idx != 8) begin n_err++; $display("FAIL bp_accepted got %0d want 8", idx); end
        n_cmp++; if (ready_in !== 1'b0) begin n_err++; $display("FAIL bp_ready_in got %b want 0", ready_in); end
        n_cmp++; if (hold_a !== hold_b) begin n_err++; $display("FAIL bp_hold got %h want %h", hold_b, hold_a); end
        for (int c = 0; c < 60; c++) begin
            if (idx < 3 * BEATS) nxt = blks[idx];
            step(idx < 3 * BEATS, 1'b1, acc, got);
            if (acc) idx++;
        end
        n_cmp++;
        if (obs_q.size() != 12 || exp_q.size() != 12) begin
            n_err++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        model_clear();
    endtask

    task automatic test_random();
        bit acc, got;
        int nb = 0;
        logic [EXP_W-1:0] cur_e = '0;
        rand_nxt($urandom_range(0, DIN_W - 1));
        for (int c = 0; c < 1000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, acc, got);
            if (acc) begin
                nb++;
                rand_nxt((nb % BEATS == 0) ? $urandom_range(0, DIN_W - 1) : $urandom_range(0, 12));
            end
        end
        for (int c = 0; c < 200 && mdl_blk.size() != 0; c++) begin
            step(1'b1, $urandom_range(0, 1) == 1, acc, got);
            if (acc) rand_nxt($urandom_range(0, DIN_W - 1));
        end
        repeat (20) step(1'b0, 1'b1, acc, got);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rand_beat%0d got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        for (int k = 0; k < obs_q.size(); k++) begin
            if (obs_q[k].sob) cur_e = obs_q[k].e;
            else begin
                n_cmp++;
                if (obs_q[k].e !== cur_e) begin n_err++; $display("FAIL rand_exp_const beat%0d got %0d want %0d", k, obs_q[k].e, cur_e); end
            end
        end
        model_clear();
    endtask

    task automatic test_reset_mid();
        bit acc, got, dz;
        // Reset after two beats of a block.
        for (int b = 0; b < 2; b++) begin rand_nxt(10); step(1'b1, 1'b1, acc, got); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        rstn = 1'b0;
        #1;
        n_cmp++; if ({ready_in, valid_out} !== 2'b10) begin n_err++; $display("FAIL rst_mid_a got %b want 10", {ready_in, valid_out}); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_clear();
        // Reset while a full block is stalled in the drain and another is partly filled.
        for (int b = 0; b < BEATS + 2; b++) begin rand_nxt(15); step(1'b1, 1'b0, acc, got); end
        step(1'b0, 1'b0, acc, got);
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL rst_mid_stall valid_out got %b want 1", valid_out); end
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        dz = 1'b1;
        for (int i = 0; i < LANES; i++) if (dout[i] !== '0) dz = 1'b0;
        n_cmp++; if ({ready_in, valid_out, sob_out, eob_out} !== 4'b1000) begin n_err++; $display("FAIL rst_mid_b flags got %b want 1000", {ready_in, valid_out, sob_out, eob_out}); end
        n_cmp++; if (exp_out !== '0 || !dz) begin n_err++; $display("FAIL rst_mid_b data exp %0d dout_zero %b want 0 1", exp_out, dz); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_clear();
        // A fresh block after release must come out alone and correct.
        for (int b = 0; b < BEATS; b++) begin rand_nxt(6 + b); step(1'b1, 1'b1, acc, got); end
        repeat (12) step(1'b0, 1'b1, acc, got);
        n_cmp++;
        if (obs_q.size() != BEATS || exp_q.size() != BEATS) begin
            n_err++; $display("FAIL rst_after_count got %0d want %0d", obs_q.size(), BEATS);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rst_after_beat%0d got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        model_clear();
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) begin
            din[i] = '0;
            nxt[i] = '0;
        end
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
